keypad_modport: RTL and testbench

- 4x4 matrix-keypad combination lock. Scans keypad columns, decodes and debounces key presses, and compares a 4-key entry against a parameterised passcode.
- Drives an enable output (unlocked), a status LED and an alert line to the authorities. An external breach input forces the alarm.
- Sits between the physical keypad and the door/alarm logic. Its port set matches the keypad_io interface.

---
 rtl/keypad_modport.sv | 197 +++++++++++++++++++
 tb/tb_keypad_modport.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/keypad_modport.sv
// keypad_modport: 4x4 matrix-keypad combination lock.
//
// Scans the keypad one column at a time, debounces key presses so that a
// held key is accepted once, collects four-key entries and compares them to
// PASSCODE. Too many wrong entries, or an external breach, latch the alarm
// until reset.
//
// Ports:
//   clk               system clock, rising-edge active
//   rst               asynchronous active-low reset
//   is_breach         external breach detect, active-high level
//   row[3:0]          keypad row returns, active-high
//   is_enabled        high while unlocked
//   led               status LED (steady in UNLOCKED, blinking in ALARM)
//   alert_authorities alarm line
//   col[3:0]          one-hot active-high column drive
module keypad_modport #(
  parameter int          SCAN_DIV     = 4,
  parameter logic [15:0] PASSCODE     = 16'h0124,
  parameter int          MAX_ATTEMPTS = 3,
  parameter int          BLINK_CYCLES = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       is_breach,
  input  logic [3:0] row,
  output logic       is_enabled,
  output logic       led,
  output logic       alert_authorities,
  output logic [3:0] col
);

  localparam int DW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int BW = (BLINK_CYCLES > 1) ? $clog2(BLINK_CYCLES) : 1;
  localparam logic [DW-1:0] DIV_LAST   = DW'(SCAN_DIV - 1);
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_CYCLES - 1);
  localparam logic [2:0]    ATT_MAX    = 3'(MAX_ATTEMPTS);

  typedef enum logic [1:0] {LOCKED, UNLOCKED, ALARM} state_t;

  logic [3:0]    r_col;
  logic [DW-1:0] r_divCnt;
  logic          r_idle;
  logic [1:0]    r_quietCnt;
  state_t        r_state, w_stateNext;
  logic [15:0]   r_entry, w_entryNext;
  logic [2:0]    r_keyCnt, w_keyCntNext;
  logic [2:0]    r_attempts, w_attemptsNext;
  logic          r_enabled, r_led, r_alert;
  logic [BW-1:0] r_blinkCnt;

  logic       w_sample;
  logic       w_keyAccept;
  logic [1:0] w_rowIdx;
  logic [1:0] w_colIdx;
  logic [3:0] w_keyCode;
  logic [2:0] w_attemptsInc;

  // Rows are only looked at on the final cycle of a column's dwell, giving
  // the keypad lines time to settle after the column switches.
  assign w_sample      = (r_divCnt == DIV_LAST);
  assign w_keyAccept   = w_sample && (row != 4'b0000) && r_idle;
  assign w_keyCode     = {w_rowIdx, w_colIdx};
  assign w_attemptsInc = r_attempts + 3'd1;

  // Lowest closed row wins when several keys in one column are down.
  always_comb begin
    w_rowIdx = 2'd0;
    if (row[0])      w_rowIdx = 2'd0;
    else if (row[1]) w_rowIdx = 2'd1;
    else if (row[2]) w_rowIdx = 2'd2;
    else if (row[3]) w_rowIdx = 2'd3;
  end

  always_comb begin
    w_colIdx = 2'd0;
    case (r_col)
      4'b0010: w_colIdx = 2'd1;
      4'b0100: w_colIdx = 2'd2;
      4'b1000: w_colIdx = 2'd3;
      default: w_colIdx = 2'd0;
    endcase
  end

  // Column scanner plus debounce: after an accept, the idle flag returns
  // only once four consecutive samples (one whole scan) saw no key at all.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_col      <= 4'b0001;
      r_divCnt   <= '0;
      r_idle     <= 1'b1;
      r_quietCnt <= 2'd0;
    end else if (w_sample) begin
      r_divCnt <= '0;
      r_col    <= {r_col[2:0], r_col[3]};
      if (row != 4'b0000) begin
        r_quietCnt <= 2'd0;
        r_idle     <= 1'b0;
      end else if (r_quietCnt == 2'd3) begin
        r_idle <= 1'b1;
      end else begin
        r_quietCnt <= r_quietCnt + 2'd1;
      end
    end else begin
      r_divCnt <= r_divCnt + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= LOCKED;
      r_entry    <= 16'h0000;
      r_keyCnt   <= 3'd0;
      r_attempts <= 3'd0;
    end else begin
      r_state    <= w_stateNext;
      r_entry    <= w_entryNext;
      r_keyCnt   <= w_keyCntNext;
      r_attempts <= w_attemptsNext;
    end
  end

  // A full entry (count of 4) is compared on the cycle after the fourth
  // key; a key can never arrive in that cycle because it is the first cycle
  // of a new column dwell. Breach overrides everything.
  always_comb begin
    w_stateNext    = r_state;
    w_entryNext    = r_entry;
    w_keyCntNext   = r_keyCnt;
    w_attemptsNext = r_attempts;
    case (r_state)
      LOCKED: begin
        if (r_keyCnt == 3'd4) begin
          w_entryNext  = 16'h0000;
          w_keyCntNext = 3'd0;
          if (r_entry == PASSCODE) begin
            w_stateNext    = UNLOCKED;
            w_attemptsNext = 3'd0;
          end else begin
            w_attemptsNext = w_attemptsInc;
            if (w_attemptsInc == ATT_MAX) w_stateNext = ALARM;
          end
        end else if (w_keyAccept) begin
          w_entryNext  = {r_entry[11:0], w_keyCode};
          w_keyCntNext = r_keyCnt + 3'd1;
        end
      end
      UNLOCKED: begin
        if (w_keyAccept && (w_keyCode == 4'hF)) begin
          w_stateNext  = LOCKED;
          w_entryNext  = 16'h0000;
          w_keyCntNext = 3'd0;
        end
      end
      ALARM: begin
        w_stateNext = ALARM;
      end
      default: begin
        w_stateNext = LOCKED;
      end
    endcase
    if (is_breach) w_stateNext = ALARM;
  end

  // Outputs follow the state register one cycle later. In ALARM the LED
  // starts lit on the first alarm output cycle and toggles every
  // BLINK_CYCLES cycles.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_enabled  <= 1'b0;
      r_led      <= 1'b0;
      r_alert    <= 1'b0;
      r_blinkCnt <= '0;
    end else begin
      r_enabled <= (r_state == UNLOCKED);
      r_alert   <= (r_state == ALARM);
      if (r_state != ALARM) begin
        r_led      <= (r_state == UNLOCKED);
        r_blinkCnt <= '0;
      end else if (!r_alert) begin
        r_led      <= 1'b1;
        r_blinkCnt <= '0;
      end else if (r_blinkCnt == BLINK_LAST) begin
        r_led      <= ~r_led;
        r_blinkCnt <= '0;
      end else begin
        r_blinkCnt <= r_blinkCnt + 1'b1;
      end
    end
  end

  assign col               = r_col;
  assign is_enabled        = r_enabled;
  assign led               = r_led;
  assign alert_authorities = r_alert;

endmodule

// File: tb/tb_keypad_modport.sv
// tb_keypad_modport: directed bench for keypad_modport. A small keypad model
// drives row from the DUT's col for the currently pressed key.
module tb_keypad_modport;

  logic       clk;
  logic       rst;
  logic       is_breach;
  logic [3:0] row;
  logic       is_enabled;
  logic       led;
  logic       alert_authorities;
  logic [3:0] col;

  logic       keyDown;
  logic [1:0] keyR;
  logic [1:0] keyC;

  int testsRun;
  int testsFailed;

  keypad_modport dut (
    .clk               (clk),
    .rst               (rst),
    .is_breach         (is_breach),
    .row               (row),
    .is_enabled        (is_enabled),
    .led               (led),
    .alert_authorities (alert_authorities),
    .col               (col)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Keypad model: the pressed key closes its row only while its column is driven.
  assign row = (keyDown && col[keyC]) ? (4'b0001 << keyR) : 4'b0000;

  task automatic doReset();
    @(negedge clk);
    rst = 1'b0;
    keyDown = 1'b0;
    is_breach = 1'b0;
    @(negedge clk);
    rst = 1'b1;
  endtask

  // Press a key until the DUT has sampled its column, then release it.
  // Returns at the negedge just after the sampling edge.
  task automatic pressKey(input logic [1:0] r, input logic [1:0] c);
    int budget;
    keyR = r;
    keyC = c;
    keyDown = 1'b1;
    budget = 0;
    while (col[c] !== 1'b1 && budget < 40) begin
      @(negedge clk);
      budget++;
    end
    while (col[c] !== 1'b0 && budget < 40) begin
      @(negedge clk);
      budget++;
    end
    keyDown = 1'b0;
    testsRun++;
    if (budget >= 40) begin
      testsFailed++;
      $display("[TB] FAIL keyScanTimeout: column %0d never sampled, waited %0d cycles, limit 40", c, budget);
    end
  endtask

  task automatic releaseWait();
    repeat (32) @(negedge clk);
  endtask

  // Enter four key codes, most significant nibble first. Returns right after
  // the sampling edge of the fourth key.
  task automatic enterCode(input logic [15:0] code);
    logic [3:0] nib;
    for (int i = 0; i < 4; i++) begin
      nib = 4'(code >> (12 - 4 * i));
      pressKey(nib[3:2], nib[1:0]);
      if (i < 3) releaseWait();
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    is_breach = 1'b0;
    keyDown = 1'b0;
    #23;
    testsRun++;
    if (col !== 4'b0001) begin testsFailed++; $display("[TB] FAIL reset_col: got %b expected 0001", col); end
    testsRun++;
    if (is_enabled !== 1'b0) begin testsFailed++; $display("[TB] FAIL reset_enabled: got %b expected 0", is_enabled); end
    testsRun++;
    if (led !== 1'b0) begin testsFailed++; $display("[TB] FAIL reset_led: got %b expected 0", led); end
    testsRun++;
    if (alert_authorities !== 1'b0) begin testsFailed++; $display("[TB] FAIL reset_alert: got %b expected 0", alert_authorities); end
    @(negedge clk);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    testsRun++;
    if (col !== 4'b0001) begin testsFailed++; $display("[TB] FAIL scan_hold: got %b expected 0001", col); end
    @(negedge clk);
    testsRun++;
    if (col !== 4'b0010) begin testsFailed++; $display("[TB] FAIL scan_rotate: got %b expected 0010", col); end
  endtask

  task automatic test_correct_code();
    doReset();
    enterCode(16'h0124);
    @(negedge clk);
    testsRun++;
    if (is_enabled !== 1'b0) begin testsFailed++; $display("[TB] FAIL unlock_early: got %b expected 0", is_enabled); end
    @(negedge clk);
    testsRun++;
    if (is_enabled !== 1'b1) begin testsFailed++; $display("[TB] FAIL unlock_enabled: got %b expected 1", is_enabled); end
    testsRun++;
    if (led !== 1'b1) begin testsFailed++; $display("[TB] FAIL unlock_led: got %b expected 1", led); end
    testsRun++;
    if (alert_authorities !== 1'b0) begin testsFailed++; $display("[TB] FAIL unlock_alert: got %b expected 0", alert_authorities); end
    releaseWait();
    pressKey(2'd3, 2'd3);
    repeat (2) @(negedge clk);
    testsRun++;
    if (is_enabled !== 1'b0) begin testsFailed++; $display("[TB] FAIL relock_enabled: got %b expected 0", is_enabled); end
    testsRun++;
    if (led !== 1'b0) begin testsFailed++; $display("[TB] FAIL relock_led: got %b expected 0", led); end
    releaseWait();
  endtask

  task automatic test_held_key();
    doReset();
    keyR = 2'd1;
    keyC = 2'd1;
    keyDown = 1'b1;
    repeat (10 * 16) @(negedge clk);
    keyDown = 1'b0;
    releaseWait();
    testsRun++;
    if (dut.r_keyCnt !== 3'd1) begin testsFailed++; $display("[TB] FAIL held_count: got %0d expected 1", dut.r_keyCnt); end
    testsRun++;
    if (dut.r_entry !== 16'h0005) begin testsFailed++; $display("[TB] FAIL held_entry: got %h expected 0005", dut.r_entry); end
    testsRun++;
    if (is_enabled !== 1'b0) begin testsFailed++; $display("[TB] FAIL held_enabled: got %b expected 0", is_enabled); end
  endtask

  task automatic test_wrong_code();
    doReset();
    for (int a = 1; a <= 2; a++) begin
      enterCode(16'h0125);
      repeat (2) @(negedge clk);
      testsRun++;
      if (alert_authorities !== 1'b0 || is_enabled !== 1'b0) begin
        testsFailed++;
        $display("[TB] FAIL wrong_%0d_state: got alert=%b en=%b expected alert=0 en=0", a, alert_authorities, is_enabled);
      end
      releaseWait();
    end
    enterCode(16'h0125);
    @(negedge clk);
    testsRun++;
    if (alert_authorities !== 1'b0) begin testsFailed++; $display("[TB] FAIL alarm_early: got %b expected 0", alert_authorities); end
    @(negedge clk);
    testsRun++;
    if (alert_authorities !== 1'b1) begin testsFailed++; $display("[TB] FAIL alarm_alert: got %b expected 1", alert_authorities); end
    testsRun++;
    if (led !== 1'b1 || is_enabled !== 1'b0) begin testsFailed++; $display("[TB] FAIL alarm_entry: got led=%b en=%b expected led=1 en=0", led, is_enabled); end
    repeat (7) @(negedge clk);
    testsRun++;
    if (led !== 1'b1) begin testsFailed++; $display("[TB] FAIL blink_hold: got %b expected 1", led); end
    @(negedge clk);
    testsRun++;
    if (led !== 1'b0) begin testsFailed++; $display("[TB] FAIL blink_off: got %b expected 0", led); end
    repeat (8) @(negedge clk);
    testsRun++;
    if (led !== 1'b1) begin testsFailed++; $display("[TB] FAIL blink_on: got %b expected 1", led); end
    releaseWait();
    enterCode(16'h0124);
    repeat (2) @(negedge clk);
    testsRun++;
    if (is_enabled !== 1'b0 || alert_authorities !== 1'b1) begin
      testsFailed++;
      $display("[TB] FAIL alarm_sticky: got en=%b alert=%b expected en=0 alert=1", is_enabled, alert_authorities);
    end
    releaseWait();
  endtask

  task automatic test_breach();
    doReset();
    enterCode(16'h0124);
    repeat (2) @(negedge clk);
    testsRun++;
    if (is_enabled !== 1'b1) begin testsFailed++; $display("[TB] FAIL breach_pre: got %b expected 1", is_enabled); end
    releaseWait();
    is_breach = 1'b1;
    @(negedge clk);
    is_breach = 1'b0;
    @(negedge clk);
    testsRun++;
    if (is_enabled !== 1'b0 || alert_authorities !== 1'b1) begin
      testsFailed++;
      $display("[TB] FAIL breach_alarm: got en=%b alert=%b expected en=0 alert=1", is_enabled, alert_authorities);
    end
    repeat (20) @(negedge clk);
    testsRun++;
    if (alert_authorities !== 1'b1) begin testsFailed++; $display("[TB] FAIL breach_hold: got %b expected 1", alert_authorities); end
    #2;
    rst = 1'b0;
    #1;
    testsRun++;
    if (alert_authorities !== 1'b0 || led !== 1'b0 || is_enabled !== 1'b0) begin
      testsFailed++;
      $display("[TB] FAIL breach_reset: got alert=%b led=%b en=%b expected 0 0 0", alert_authorities, led, is_enabled);
    end
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_async_reset();
    doReset();
    pressKey(2'd0, 2'd0);
    releaseWait();
    pressKey(2'd0, 2'd1);
    #2;
    rst = 1'b0;
    #1;
    testsRun++;
    if (col !== 4'b0001) begin testsFailed++; $display("[TB] FAIL async_col: got %b expected 0001", col); end
    testsRun++;
    if (is_enabled !== 1'b0 || led !== 1'b0 || alert_authorities !== 1'b0) begin
      testsFailed++;
      $display("[TB] FAIL async_outputs: got en=%b led=%b alert=%b expected 0 0 0", is_enabled, led, alert_authorities);
    end
    @(negedge clk);
    rst = 1'b1;
    enterCode(16'h0124);
    repeat (2) @(negedge clk);
    testsRun++;
    if (is_enabled !== 1'b1) begin testsFailed++; $display("[TB] FAIL async_unlock: got %b expected 1", is_enabled); end
    releaseWait();
  endtask

  initial begin
    testsRun = 0;
    testsFailed = 0;
    keyDown = 1'b0;
    keyR = 2'd0;
    keyC = 2'd0;
    is_breach = 1'b0;
    rst = 1'b0;
    test_reset();
    test_correct_code();
    test_held_key();
    test_wrong_code();
    test_breach();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
